// File: rtl/fft_mux_pkg.sv
// Shared types and helpers for the FFT sample-mux sequencer.
// Holds the select width, the sequencer state enum and the bit-reverse helper.
package fft_mux_pkg;

    localparam int FFT_MAX_LOG2  = 11;
    localparam int FFT_SEL_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } seq_state_t;

    // Reverse the low nbits of idx. The full-width reversal is shifted back down,
    // so every bit above nbits-1 comes out zero.
    function automatic logic [FFT_SEL_WIDTH-1:0] bitrev(
        input logic [FFT_SEL_WIDTH-1:0] idx,
        input logic [3:0]               nbits
    );
        logic [FFT_SEL_WIDTH-1:0] full;
        for (int i = 0; i < FFT_SEL_WIDTH; i++) begin
            full[i] = idx[FFT_SEL_WIDTH-1-i];
        end
        return full >> (4'(FFT_SEL_WIDTH) - nbits);
    endfunction

endpackage

// File: rtl/fft_mux_seq_fifo.sv
// Count-based synchronous FIFO that buffers mux samples for the output stream.
// Push and pop may happen in the same cycle even when full; clr empties it at once.
module fft_mux_seq_fifo #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fft_mux_seq_ctrl.sv
// Frame sequencer and output buffer for the pipelined 2048-to-1 FFT sample mux.
// Optional abort support is compiled in with FFT_MUX_SEQ_ABORT_EN.
module fft_mux_seq_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int MUX_LATENCY = 3,
    parameter int SEL_WIDTH   = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            len_log2,
    input  logic                  bitrev,
    output logic [SEL_WIDTH-1:0]  sel,
    input  logic [DATA_WIDTH-1:0] mux_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
`ifdef FFT_MUX_SEQ_ABORT_EN
    ,
    input  logic                  abort,
    output logic                  aborted
`endif
);

    import fft_mux_pkg::*;

    localparam int FIFO_DEPTH = MUX_LATENCY + 2;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int IW         = FFT_SEL_WIDTH + 1;

    seq_state_t               state;
    seq_state_t               state_n;
    logic [FFT_SEL_WIDTH-1:0] idx;
    logic [FFT_SEL_WIDTH-1:0] last_idx;
    logic [FFT_SEL_WIDTH-1:0] next_idx;
    logic [FFT_SEL_WIDTH-1:0] next_sel;
    logic [3:0]               len_q;
    logic                     bitrev_q;
    logic [3:0]               len_eff;
    logic [IW-1:0]            frame_len;
    logic [SEL_WIDTH-1:0]     sel_q;
    logic [MUX_LATENCY-1:0]   flag_sr;
    logic [MUX_LATENCY-1:0]   last_sr;
    logic                     issue;
    logic                     issue_last;
    logic                     done_c;
    logic                     abort_hit;
    logic                     credit_ok;
    logic                     push;
    logic                     pop;
    logic [DATA_WIDTH:0]      head;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [CW-1:0]            fifo_count;
    int                       inflight;

    // Out-of-range lengths fall back to the full 2048-sample frame.
    assign len_eff   = (len_log2 == 4'd0 || len_log2 > 4'(FFT_MAX_LOG2)) ? 4'(FFT_MAX_LOG2) : len_log2;
    assign frame_len = IW'(1) << len_eff;

    assign inflight   = $countones(flag_sr);
    assign credit_ok  = (inflight + int'(fifo_count)) < FIFO_DEPTH;
    assign issue_last = issue && (idx == last_idx);
    assign next_idx   = idx + 1'b1;
    assign next_sel   = bitrev_q ? fft_mux_pkg::bitrev(next_idx, len_q) : next_idx;

`ifdef FFT_MUX_SEQ_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Issue only while the samples already in the mux pipe plus those buffered
    // leave a free FIFO slot, since the mux pipe itself cannot be stalled.
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        done_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                issue = credit_ok;
                if (issue && idx == last_idx) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == 0 && fifo_empty) begin
                    done_c  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort_hit) begin
            state_n = IDLE;
            issue   = 1'b0;
            done_c  = 1'b0;
        end
    end

    // sel is preloaded with the next frame position so it is already stable
    // during the cycle that issues it; after the final issue it simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            last_idx <= '0;
            len_q    <= '0;
            bitrev_q <= 1'b0;
            sel_q    <= '0;
        end else if (state == IDLE && start) begin
            idx      <= '0;
            last_idx <= FFT_SEL_WIDTH'(frame_len - 1'b1);
            len_q    <= len_eff;
            bitrev_q <= bitrev;
            sel_q    <= '0;
        end else if (issue && !issue_last) begin
            idx      <= next_idx;
            sel_q    <= SEL_WIDTH'(next_sel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_sr <= '0;
            last_sr <= '0;
        end else if (abort_hit) begin
            flag_sr <= '0;
            last_sr <= '0;
        end else begin
            flag_sr <= (flag_sr << 1) | MUX_LATENCY'(issue);
            last_sr <= (last_sr << 1) | MUX_LATENCY'(issue_last);
        end
    end

`ifdef FFT_MUX_SEQ_ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted <= 1'b0;
        end else begin
            aborted <= abort_hit;
        end
    end
`endif

    assign push = flag_sr[MUX_LATENCY-1];
    assign pop  = m_valid && m_ready;

    fft_mux_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (abort_hit),
        .push      (push),
        .push_data ({mux_data, last_sr[MUX_LATENCY-1]}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop && !abort_hit));

    assign sel     = sel_q;
    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : head[DATA_WIDTH:1];
    assign m_last  = !fifo_empty && head[0];
    assign busy    = (state != IDLE);
    assign done    = done_c;

endmodule

// File: tb/tb_fft_mux_seq_ctrl.sv
// Self-checking bench for fft_mux_seq_ctrl: a frame-level reference model plus directed scenarios.
// Abort scenarios are included when FFT_MUX_SEQ_ABORT_EN is defined.
module tb_fft_mux_seq_ctrl;

    localparam int DW    = 8;
    localparam int LAT   = 3;
    localparam int SW    = 11;
    localparam int DEPTH = LAT + 2;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic [3:0]    len_log2 = 4'd0;
    logic          bitrev   = 1'b0;
    logic          m_ready  = 1'b0;
    logic [SW-1:0] sel;
    logic [DW-1:0] mux_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;
`ifdef FFT_MUX_SEQ_ABORT_EN
    logic          abort = 1'b0;
    logic          aborted;
`endif

    always #5 clk = ~clk;

    fft_mux_seq_ctrl #(
        .DATA_WIDTH  (DW),
        .MUX_LATENCY (LAT),
        .SEL_WIDTH   (SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len_log2 (len_log2),
        .bitrev   (bitrev),
        .sel      (sel),
        .mux_data (mux_data),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .busy     (busy),
        .done     (done)
`ifdef FFT_MUX_SEQ_ABORT_EN
        ,
        .abort    (abort),
        .aborted  (aborted)
`endif
    );

    // Three-stage mux pipe whose input array holds data_i[k] = k + 0x10.
    logic [DW-1:0] mp0, mp1, mp2;
    always @(posedge clk) begin
        mp0 <= DW'(sel + 16);
        mp1 <= mp0;
        mp2 <= mp1;
    end
    assign mux_data = mp2;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  data;
        logic        last;
    } flight_t;
    typedef struct {
        logic [7:0]  data;
        logic        last;
    } samp_t;

    flight_t inflight_q[$];
    samp_t   fifo_q[$];
    int      order[$];
    int      pos;
    int      mstate;
    bit      exp_aborted;

    int start_cyc, rx_cnt, last_cnt, done_cnt, first_valid_cyc, first_issue_cyc, done_cyc, issue_cnt, last_data;
    int seen_sel[$];
    int seen_data[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cycle);
        end
    endtask

    // Frame model: order from plain arithmetic, a queue of issues in flight that
    // land three cycles later, and a queue standing in for the output buffer.
    always @(negedge clk) begin
        bit         e_valid, e_issue, e_done, abort_now;
        int         cur, len_eff, n, r;
        flight_t    f;
        samp_t      s;
        if (!rst_n) begin
            inflight_q.delete();
            fifo_q.delete();
            order.delete();
            pos         = 0;
            mstate      = 0;
            exp_aborted = 1'b0;
        end else begin
            e_valid = (fifo_q.size() > 0);
            e_issue = (mstate == 1) && (inflight_q.size() + fifo_q.size() < DEPTH);
            e_done  = (mstate == 2) && (inflight_q.size() == 0) && (fifo_q.size() == 0);

            checkOutput("m_valid", m_valid, e_valid);
            checkOutput("busy", busy, mstate != 0);
            checkOutput("done", done, e_done);
            if (e_valid) begin
                checkOutput("m_data", m_data, fifo_q[0].data);
                checkOutput("m_last", m_last, fifo_q[0].last);
            end
            if (e_issue) begin
                checkOutput("sel", sel, order[pos]);
            end
`ifdef FFT_MUX_SEQ_ABORT_EN
            checkOutput("aborted", aborted, exp_aborted);
            abort_now = abort && (mstate != 0);
`else
            abort_now = 1'b0;
`endif

            if (m_valid && m_ready) begin
                rx_cnt++;
                seen_data.push_back(int'(m_data));
                if (m_last) begin
                    last_cnt++;
                    last_data = int'(m_data);
                end
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cycle;
            if (done) begin
                done_cnt++;
                done_cyc = cycle;
            end
            if (e_issue) begin
                seen_sel.push_back(int'(sel));
                issue_cnt++;
                if (first_issue_cyc < 0) first_issue_cyc = cycle;
            end

            exp_aborted = abort_now;
            if (abort_now) begin
                inflight_q.delete();
                fifo_q.delete();
                mstate = 0;
            end else begin
                cur = mstate;
                if (e_valid && m_ready) fifo_q.delete(0);
                if (inflight_q.size() > 0 && inflight_q[0].cyc == cycle - 3) begin
                    s.data = inflight_q[0].data;
                    s.last = inflight_q[0].last;
                    fifo_q.push_back(s);
                    inflight_q.delete(0);
                end
                if (e_issue) begin
                    f.cyc  = cycle;
                    f.data = 8'(order[pos] + 16);
                    f.last = (pos == order.size() - 1);
                    inflight_q.push_back(f);
                    pos++;
                    if (pos == order.size()) mstate = 2;
                end
                if (e_done) mstate = 0;
                if (cur == 0 && start) begin
                    len_eff = (len_log2 == 0 || len_log2 > 11) ? 11 : int'(len_log2);
                    n = 1 << len_eff;
                    order.delete();
                    for (int i = 0; i < n; i++) begin
                        r = i;
                        if (bitrev) begin
                            r = 0;
                            for (int b = 0; b < len_eff; b++) begin
                                if (((i >> b) & 1) != 0) r |= 1 << (len_eff - 1 - b);
                            end
                        end
                        order.push_back(r);
                    end
                    pos    = 0;
                    mstate = 1;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] l, input bit br, input bit rdy);
        @(posedge clk);
        #1;
        len_log2        = l;
        bitrev          = br;
        m_ready         = rdy;
        start           = 1'b1;
        start_cyc       = cycle;
        rx_cnt          = 0;
        last_cnt        = 0;
        done_cnt        = 0;
        issue_cnt       = 0;
        last_data       = -1;
        first_valid_cyc = -1;
        first_issue_cyc = -1;
        done_cyc        = -1;
        seen_sel.delete();
        seen_data.delete();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget, input bit rnd);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            #1;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            n++;
        end
        checkOutput({name, "_done_seen"}, done_cnt > 0, 1);
        m_ready = 1'b1;
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_sel"}, sel, 0);
        checkOutput({name, "_m_valid"}, m_valid, 0);
        checkOutput({name, "_m_last"}, m_last, 0);
        checkOutput({name, "_m_data"}, m_data, 0);
        checkOutput({name, "_busy"}, busy, 0);
        checkOutput({name, "_done"}, done, 0);
`ifdef FFT_MUX_SEQ_ABORT_EN
        checkOutput({name, "_aborted"}, aborted, 0);
`endif
    endtask

    initial begin
        int br_exp[8];
        br_exp = '{0, 4, 2, 6, 1, 5, 3, 7};

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #2;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] natural order, len_log2=3");
        applyStimulus(4'd3, 1'b0, 1'b1);
        waitDone("nat", 100, 1'b0);
        checkOutput("nat_first_issue", first_issue_cyc - start_cyc, 1);
        checkOutput("nat_first_valid", first_valid_cyc - start_cyc, 5);
        checkOutput("nat_done_cycle", done_cyc - start_cyc, 13);
        checkOutput("nat_rx", rx_cnt, 8);
        checkOutput("nat_last_cnt", last_cnt, 1);
        checkOutput("nat_last_data", last_data, 'h17);
        checkOutput("nat_sel_cnt", seen_sel.size(), 8);
        checkOutput("nat_data_cnt", seen_data.size(), 8);
        if (seen_sel.size() == 8 && seen_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                checkOutput($sformatf("nat_sel%0d", i), seen_sel[i], i);
                checkOutput($sformatf("nat_data%0d", i), seen_data[i], 'h10 + i);
            end
        end

        $display("[TB] bit-reversed order, len_log2=3");
        applyStimulus(4'd3, 1'b1, 1'b1);
        waitDone("br", 100, 1'b0);
        checkOutput("br_rx", rx_cnt, 8);
        checkOutput("br_last_data", last_data, 'h17);
        checkOutput("br_sel_cnt", seen_sel.size(), 8);
        checkOutput("br_data_cnt", seen_data.size(), 8);
        if (seen_sel.size() == 8 && seen_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                checkOutput($sformatf("br_sel%0d", i), seen_sel[i], br_exp[i]);
                checkOutput($sformatf("br_data%0d", i), seen_data[i], 'h10 + br_exp[i]);
            end
        end

        $display("[TB] backpressure, len_log2=4");
        applyStimulus(4'd4, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_issues", issue_cnt, 5);
        checkOutput("bp_sel_held", sel, 5);
        checkOutput("bp_valid", m_valid, 1);
        checkOutput("bp_rx", rx_cnt, 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        waitDone("bp", 200, 1'b0);
        checkOutput("bp_rx_total", rx_cnt, 16);
        checkOutput("bp_last_cnt", last_cnt, 1);
        checkOutput("bp_data_cnt", seen_data.size(), 16);
        if (seen_data.size() == 16) begin
            for (int i = 0; i < 16; i++) checkOutput($sformatf("bp_data%0d", i), seen_data[i], 'h10 + i);
        end

        $display("[TB] random ready, len_log2=11");
        applyStimulus(4'd11, 1'b0, 1'b1);
        waitDone("rnd", 20000, 1'b1);
        checkOutput("rnd_rx", rx_cnt, 2048);
        checkOutput("rnd_last_cnt", last_cnt, 1);
        checkOutput("rnd_done_cnt", done_cnt, 1);

        $display("[TB] len_log2=0 means 2048");
        applyStimulus(4'd0, 1'b0, 1'b1);
        waitDone("len0", 5000, 1'b0);
        checkOutput("len0_rx", rx_cnt, 2048);

        $display("[TB] len_log2=1");
        applyStimulus(4'd1, 1'b0, 1'b1);
        waitDone("len1", 100, 1'b0);
        checkOutput("len1_rx", rx_cnt, 2);
        checkOutput("len1_sel_cnt", seen_sel.size(), 2);
        if (seen_sel.size() == 2) begin
            checkOutput("len1_sel0", seen_sel[0], 0);
            checkOutput("len1_sel1", seen_sel[1], 1);
        end

        $display("[TB] start while busy");
        applyStimulus(4'd3, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        start    = 1'b1;
        len_log2 = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone("busy_start", 100, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("busy_start_rx", rx_cnt, 8);
        checkOutput("busy_start_done_cnt", done_cnt, 1);
        checkOutput("busy_start_idle", busy, 0);

        $display("[TB] reset mid-run");
        applyStimulus(4'd4, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_no_done", done_cnt, 0);
        checkOutput("midrst_idle", busy, 0);

`ifdef FFT_MUX_SEQ_ABORT_EN
        $display("[TB] abort in cycle 6");
        applyStimulus(4'd4, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        checkOutput("abort_cycle", cycle - start_cyc, 6);
        checkOutput("abort_valid_before", m_valid, 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_valid_after", m_valid, 0);
        checkOutput("abort_pulse", aborted, 1);
        checkOutput("abort_idle", busy, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("abort_no_done", done_cnt, 0);
        applyStimulus(4'd3, 1'b0, 1'b1);
        waitDone("post_abort", 100, 1'b0);
        checkOutput("post_abort_rx", rx_cnt, 8);
        checkOutput("post_abort_last", last_data, 'h17);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
